traffic_phase_scheduler: RTL and testbench

//  Demand-actuated phase scheduler for a four-approach intersection (N,E,S,W).
//  - Latches vehicle-detector requests.
//  - Serves approaches round-robin, skipping those with no demand.
//  - Enforces min/max green, yellow and all-red clearance times.
//  - Handles emergency-vehicle preemption.
//  - Drives per-approach lamp outputs and a phase code consistent with the fixed-cycle sequencer encoding.

---
 rtl/traffic_pkg.sv | 30 +++
 rtl/tl_rr_picker.sv | 24 ++
 rtl/traffic_phase_scheduler.sv | 117 +++++++++++
 tb/tb_traffic_phase_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared direction, phase-code and FSM-state definitions for the intersection phase scheduler.
package traffic_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Phase code is {dir, is_yellow}, matching the fixed-cycle sequencer.
    localparam logic [2:0] north_g = 3'b000;
    localparam logic [2:0] north_y = 3'b001;
    localparam logic [2:0] east_g  = 3'b010;
    localparam logic [2:0] east_y  = 3'b011;
    localparam logic [2:0] south_g = 3'b100;
    localparam logic [2:0] south_y = 3'b101;
    localparam logic [2:0] west_g  = 3'b110;
    localparam logic [2:0] west_y  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Round-robin picker: first set bit of dem at or after start, wrapping around.
module tl_rr_picker (
    input  logic [3:0] dem,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        valid = |dem;
        idx   = start;
        cand  = start;
        for (int k = 3; k >= 0; k--) begin
            cand = start + k[1:0];
            if (dem[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-approach phase scheduler with min/max green, yellow,
// all-red clearance and emergency preemption.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TMR_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             emg_req,
    input  logic [1:0]       emg_dir,
    output logic [3:0]       green,
    output logic [3:0]       yellow,
    output logic [2:0]       phase,
    output logic             all_red,
    output logic             emg_ack,
    output logic [TMR_W-1:0] tmr,
    output logic [1:0]       fsm_state
);

    localparam logic [TMR_W-1:0] TMR_SAT = '1;
    localparam logic [TMR_W-1:0] GMIN_L  = TMR_W'(GREEN_MIN - 1);
    localparam logic [TMR_W-1:0] GMAX_L  = TMR_W'(GREEN_MAX - 1);
    localparam logic [TMR_W-1:0] YEL_L   = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] AR_L    = TMR_W'(ALLRED_T - 1);

    state_t           state, state_next;
    logic [1:0]       cur, cur_next;
    logic [3:0]       dem, dem_next, dem_eff, other;
    logic [TMR_W-1:0] tmr_next;
    logic             rr_valid, go, enter_green, change;
    logic [1:0]       rr_idx, pick;

    // A request seen this cycle counts as demand without waiting for the latch.
    assign dem_eff = dem | req;
    assign other   = dem_eff & ~dir_onehot(cur);

    tl_rr_picker u_picker (
        .dem   (dem_eff),
        .start (cur + 2'd1),
        .valid (rr_valid),
        .idx   (rr_idx)
    );

    assign pick = emg_req ? emg_dir : rr_idx;
    assign go   = emg_req | rr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= DIR_N;
            dem   <= 4'b0000;
            tmr   <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            dem   <= dem_next;
            tmr   <= tmr_next;
        end
    end

    always_comb begin
        state_next = state;
        cur_next   = cur;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = GREEN;
                    cur_next   = pick;
                end
            end
            GREEN: begin
                // Preemption for another approach bypasses minimum green.
                if (emg_req) begin
                    if (emg_dir != cur) state_next = YELLOW;
                end else if (|other && (tmr >= GMAX_L || (tmr >= GMIN_L && !req[cur]))) begin
                    state_next = YELLOW;
                end
            end
            YELLOW: begin
                if (tmr == YEL_L) state_next = ALLRED;
            end
            ALLRED: begin
                if (tmr == AR_L) begin
                    if (go) begin
                        state_next = GREEN;
                        cur_next   = pick;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign change      = (state_next != state);
    assign enter_green = change && (state_next == GREEN);
    // Clearing on green entry overrides a same-cycle detector hit.
    assign dem_next    = dem_eff & ~(enter_green ? dir_onehot(cur_next) : 4'b0000);
    assign tmr_next    = change ? '0 : ((tmr == TMR_SAT) ? tmr : tmr + TMR_W'(1));

    always_comb begin
        green     = (state == GREEN)  ? dir_onehot(cur) : 4'b0000;
        yellow    = (state == YELLOW) ? dir_onehot(cur) : 4'b0000;
        all_red   = (state == IDLE) || (state == ALLRED);
        phase     = {cur, state == YELLOW};
        emg_ack   = (state == GREEN) && emg_req && (emg_dir == cur);
        fsm_state = state;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for the phase scheduler: hand-computed lamp, phase and timer expectations.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       emg_req;
    logic [1:0] emg_dir;
    logic [3:0] green, yellow;
    logic [2:0] phase;
    logic       all_red, emg_ack;
    logic [7:0] tmr;
    logic [1:0] fsm_state;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    traffic_phase_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .emg_req   (emg_req),
        .emg_dir   (emg_dir),
        .green     (green),
        .yellow    (yellow),
        .phase     (phase),
        .all_red   (all_red),
        .emg_ack   (emg_ack),
        .tmr       (tmr),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        emg_req = 1'b0;
        emg_dir = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Applies one request vector from IDLE and aligns cyc=0 with the green entry.
    task automatic enter(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        // 1: reset values and idle with no demand
        rst_n = 1'b0; req = 4'b0000; emg_req = 1'b0; emg_dir = 2'd0;
        #1;
        chk("rst_green", {4'b0, green}, 8'h00);
        chk("rst_yellow", {4'b0, yellow}, 8'h00);
        chk("rst_all_red", {7'b0, all_red}, 8'h01);
        chk("rst_phase", {5'b0, phase}, 8'h00);
        chk("rst_emg_ack", {7'b0, emg_ack}, 8'h00);
        chk("rst_tmr", tmr, 8'h00);
        chk("rst_state", {6'b0, fsm_state}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_all_red", {7'b0, all_red}, 8'h01);
            chk("idle_green", {4'b0, green}, 8'h00);
        end
        chk("idle_tmr", tmr, 8'd50);

        // 2: N pulse, rest on green, timer saturates
        enter(4'b0001);
        req = 4'b0000;
        chk("n_green", {4'b0, green}, 8'h01);
        chk("n_phase", {5'b0, phase}, 8'h00);
        chk("n_tmr0", tmr, 8'h00);
        chk("n_state", {6'b0, fsm_state}, 8'h01);
        run_to(260);
        chk("n_rest_green", {4'b0, green}, 8'h01);
        chk("n_tmr_sat", tmr, 8'hff);

        // 3: N -> E at minimum green
        do_reset();
        enter(4'b0001);
        req = 4'b0010;
        run_to(3);
        chk("min_green_n", {4'b0, green}, 8'h01);
        chk("min_tmr3", tmr, 8'd3);
        run_to(4);
        chk("min_yellow_n", {4'b0, yellow}, 8'h01);
        chk("min_phase_ny", {5'b0, phase}, 8'h01);
        chk("min_green_off", {4'b0, green}, 8'h00);
        run_to(8);
        chk("min_yellow_tmr4", tmr, 8'd4);
        run_to(9);
        chk("min_allred", {7'b0, all_red}, 8'h01);
        chk("min_allred_yel", {4'b0, yellow}, 8'h00);
        run_to(10);
        chk("min_allred2", {7'b0, all_red}, 8'h01);
        run_to(11);
        chk("min_green_e", {4'b0, green}, 8'h02);
        chk("min_phase_eg", {5'b0, phase}, 8'h02);
        chk("min_e_tmr0", tmr, 8'h00);
        req = 4'b0000;

        // 4: N held, S waiting -> max green; E skipped, latched N served again
        do_reset();
        enter(4'b0001);
        req = 4'b0101;
        run_to(15);
        chk("max_green_n", {4'b0, green}, 8'h01);
        chk("max_tmr15", tmr, 8'd15);
        run_to(16);
        chk("max_yellow_n", {4'b0, yellow}, 8'h01);
        req = 4'b0000;
        run_to(22);
        chk("max_allred", {7'b0, all_red}, 8'h01);
        run_to(23);
        chk("max_green_s", {4'b0, green}, 8'h04);
        chk("max_phase_sg", {5'b0, phase}, 8'h04);
        run_to(27);
        chk("max_yellow_s", {4'b0, yellow}, 8'h04);
        run_to(34);
        chk("max_green_n2", {4'b0, green}, 8'h01);

        // 5: E,S,W,N demand pulse -> served in rotation
        do_reset();
        enter(4'b0001);
        req = 4'b1111;
        step();
        req = 4'b0000;
        run_to(4);
        chk("rr_yellow_n", {4'b0, yellow}, 8'h01);
        run_to(11);
        chk("rr_green_e", {4'b0, green}, 8'h02);
        run_to(22);
        chk("rr_green_s", {4'b0, green}, 8'h04);
        run_to(33);
        chk("rr_green_w", {4'b0, green}, 8'h08);
        chk("rr_phase_wg", {5'b0, phase}, 8'h06);
        run_to(37);
        chk("rr_yellow_w", {4'b0, yellow}, 8'h08);
        chk("rr_phase_wy", {5'b0, phase}, 8'h07);
        run_to(44);
        chk("rr_green_n", {4'b0, green}, 8'h01);
        run_to(60);
        chk("rr_rest_n", {4'b0, green}, 8'h01);

        // 6: emergency preemption of E by W
        do_reset();
        enter(4'b0010);
        req = 4'b0000;
        chk("emg_green_e", {4'b0, green}, 8'h02);
        step();
        chk("emg_e_tmr1", tmr, 8'd1);
        emg_req = 1'b1;
        emg_dir = 2'd3;
        run_to(2);
        chk("emg_yellow_e", {4'b0, yellow}, 8'h02);
        chk("emg_ack_off", {7'b0, emg_ack}, 8'h00);
        run_to(6);
        chk("emg_yellow_full", {4'b0, yellow}, 8'h02);
        run_to(7);
        chk("emg_allred", {7'b0, all_red}, 8'h01);
        run_to(9);
        chk("emg_green_w", {4'b0, green}, 8'h08);
        chk("emg_ack_on", {7'b0, emg_ack}, 8'h01);
        run_to(29);
        chk("emg_hold_w", {4'b0, green}, 8'h08);
        chk("emg_hold_tmr", tmr, 8'd20);
        chk("emg_hold_ack", {7'b0, emg_ack}, 8'h01);
        emg_req = 1'b0;
        step();
        chk("emg_release_ack", {7'b0, emg_ack}, 8'h00);
        chk("emg_release_w", {4'b0, green}, 8'h08);

        // 7: asynchronous reset during YELLOW(S)
        do_reset();
        enter(4'b0100);
        req = 4'b0001;
        chk("ar_green_s", {4'b0, green}, 8'h04);
        run_to(4);
        chk("ar_yellow_s", {4'b0, yellow}, 8'h04);
        chk("ar_phase_sy", {5'b0, phase}, 8'h05);
        run_to(6);
        chk("ar_yel_tmr2", tmr, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_all_red", {7'b0, all_red}, 8'h01);
        chk("ar_yellow_off", {4'b0, yellow}, 8'h00);
        chk("ar_green_off", {4'b0, green}, 8'h00);
        chk("ar_tmr0", tmr, 8'h00);
        chk("ar_state", {6'b0, fsm_state}, 8'h00);
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
